// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: resolves one palette pixel per request from a matched
// sprite descriptor, fetching the texel over a stb/ack memory handshake.
module sprite_pixel_fetch #(
    parameter int ADDR_W  = 16,
    parameter int PIX_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_hit,
    input  logic [63:0]       in_sprite,
    input  logic [9:0]        hcursor,
    input  logic [9:0]        vcursor,
    output logic              mem_stb,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [PIX_W-1:0]  mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_opaque,
    output logic [9:0]        out_hcursor,
    output logic              fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        REQ,
        OUT
    } state_t;

    state_t            state_q, state_d;
    logic [55:0]       spr_q, spr_d;
    logic              hit_q, hit_d;
    logic [9:0]        hcur_q, hcur_d;
    logic [9:0]        vcur_q, vcur_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              opq_q, opq_d;
    logic              err_q, err_d;

    logic              unused_rsvd;
    assign unused_rsvd = ^in_sprite[63:56];

    logic [9:0]  hpos;
    logic [8:0]  vpos;
    logic [5:0]  wid;
    logic [5:0]  hgt;
    logic        en;
    logic [15:0] base;
    logic [7:0]  palofs;

    assign hpos   = spr_q[9:0];
    assign vpos   = spr_q[18:10];
    assign wid    = spr_q[24:19];
    assign hgt    = spr_q[30:25];
    assign en     = spr_q[31];
    assign base   = spr_q[47:32];
    assign palofs = spr_q[55:48];

    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [10:0]       vbot;
    logic              vhit;
    logic [6:0]        span;
    logic [16:0]       prod;
    logic [ADDR_W-1:0] addr_calc;
    logic              fetch_go;
    logic              tmo;
    logic [PIX_W-1:0]  tint;

    // dx wraps when hcursor < HPOS, so a single compare rejects both sides
    assign dx        = hcur_q - hpos;
    assign dy        = vcur_q - {1'b0, vpos};
    assign vbot      = {2'b00, vpos} + {5'b00000, hgt};
    assign vhit      = ({1'b0, vcur_q} >= {2'b00, vpos}) &&
                       ({1'b0, vcur_q} <= vbot);
    assign span      = {1'b0, wid} + 7'd1;
    assign prod      = {7'd0, dy} * {10'd0, span};
    assign addr_calc = ADDR_W'(base) + ADDR_W'(prod) + ADDR_W'(dx);
    assign fetch_go  = hit_q && en && vhit && (dx <= {4'd0, wid});
    assign tmo       = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign tint      = mem_data + PIX_W'(palofs);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            spr_q   <= '0;
            hit_q   <= 1'b0;
            hcur_q  <= '0;
            vcur_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            pix_q   <= '0;
            opq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            spr_q   <= spr_d;
            hit_q   <= hit_d;
            hcur_q  <= hcur_d;
            vcur_q  <= vcur_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            opq_q   <= opq_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        spr_d   = spr_q;
        hit_d   = hit_q;
        hcur_d  = hcur_q;
        vcur_d  = vcur_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        opq_d   = opq_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    spr_d   = in_sprite[55:0];
                    hit_d   = in_hit;
                    hcur_d  = hcursor;
                    vcur_d  = vcursor;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (fetch_go) begin
                    addr_d  = addr_calc;
                    cnt_d   = '0;
                    state_d = REQ;
                end else begin
                    pix_d   = '0;
                    opq_d   = 1'b0;
                    state_d = OUT;
                end
            end
            REQ: begin
                // ack wins over a timeout landing on the same cycle
                if (mem_ack) begin
                    if (mem_data == '0) begin
                        pix_d = '0;
                        opq_d = 1'b0;
                    end else begin
                        pix_d = tint;
                        opq_d = 1'b1;
                    end
                    state_d = OUT;
                end else if (tmo) begin
                    pix_d   = '0;
                    opq_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign mem_stb     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign out_valid   = (state_q == OUT);
    assign out_pixel   = pix_q;
    assign out_opaque  = opq_q;
    assign out_hcursor = hcur_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: vector table plus reset,
// stray-ack and backpressure sequences.
module tb_sprite_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_hit;
    logic [63:0] in_sprite;
    logic [9:0]  hcursor;
    logic [9:0]  vcursor;
    logic        mem_stb;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pixel;
    logic        out_opaque;
    logic [9:0]  out_hcursor;
    logic        fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sprite_pixel_fetch #(
        .ADDR_W (16),
        .PIX_W  (8),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_hit     (in_hit),
        .in_sprite  (in_sprite),
        .hcursor    (hcursor),
        .vcursor    (vcursor),
        .mem_stb    (mem_stb),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_opaque (out_opaque),
        .out_hcursor(out_hcursor),
        .fetch_err  (fetch_err)
    );

    typedef struct {
        logic [63:0] spr;
        logic        hit;
        logic [9:0]  hc;
        logic [9:0]  vc;
        int          dly;
        logic [7:0]  data;
        logic        fetch;
        logic [15:0] addr;
        logic [7:0]  pix;
        logic        opq;
        int          lat;
        int          hold;
        logic        err;
    } vec_t;

    vec_t tv[11];

    function automatic logic [63:0] mk(
        input logic [9:0] hp, input logic [8:0] vp,
        input logic [5:0] w, input logic [5:0] h, input logic en,
        input logic [15:0] b, input logic [7:0] p);
        return {8'h00, p, b, en, h, w, vp, hp};
    endfunction

    function automatic vec_t mv(
        input logic [63:0] spr, input logic hit,
        input logic [9:0] hc, input logic [9:0] vc,
        input int dly, input logic [7:0] data, input logic fetch,
        input logic [15:0] addr, input logic [7:0] pix,
        input logic opq, input int lat, input int hold,
        input logic err);
        vec_t v;
        v.spr = spr; v.hit = hit; v.hc = hc; v.vc = vc;
        v.dly = dly; v.data = data; v.fetch = fetch;
        v.addr = addr; v.pix = pix; v.opq = opq;
        v.lat = lat; v.hold = hold; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int id);
        int  lat;
        int  stbc;
        bit  done;
        @(negedge clk);
        chk($sformatf("v%0d idle in_ready", id), in_ready, 1);
        in_valid  = 1'b1;
        in_sprite = v.spr;
        in_hit    = v.hit;
        hcursor   = v.hc;
        vcursor   = v.vc;
        mem_ack   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 0;
        stbc = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            lat++;
            if (out_valid) begin
                done = 1;
            end else begin
                chk($sformatf("v%0d busy in_ready", id), in_ready, 0);
                if (mem_stb) begin
                    stbc++;
                    chk($sformatf("v%0d mem_addr", id), mem_addr, v.addr);
                    mem_ack  = (stbc == v.dly + 1);
                    mem_data = v.data;
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        chk($sformatf("v%0d out_valid seen", id), done, 1);
        chk($sformatf("v%0d fetched", id), stbc != 0, v.fetch);
        chk($sformatf("v%0d latency", id), lat, v.lat);
        chk($sformatf("v%0d out_pixel", id), out_pixel, v.pix);
        chk($sformatf("v%0d out_opaque", id), out_opaque, v.opq);
        chk($sformatf("v%0d out_hcursor", id), out_hcursor, v.hc);
        chk($sformatf("v%0d fetch_err", id), fetch_err, v.err);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk($sformatf("v%0d hold valid", id), out_valid, 1);
            chk($sformatf("v%0d hold in_ready", id), in_ready, 0);
            chk($sformatf("v%0d hold pixel", id), out_pixel, v.pix);
            chk($sformatf("v%0d hold opaque", id), out_opaque, v.opq);
            chk($sformatf("v%0d hold hcur", id), out_hcursor, v.hc);
            chk($sformatf("v%0d hold stb", id), mem_stb, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d post valid", id), out_valid, 0);
        chk($sformatf("v%0d post in_ready", id), in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t r;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_hit    = 1'b0;
        in_sprite = '0;
        hcursor   = '0;
        vcursor   = '0;
        mem_ack   = 1'b0;
        mem_data  = '0;
        out_ready = 1'b0;

        tv[0]  = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 1, 105, 22,
                    2, 8'h03, 1, 16'h1025, 8'h13, 1, 5, 5, 0);
        tv[1]  = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 0, 105, 22,
                    0, 8'h03, 0, 16'h0000, 8'h00, 0, 2, 0, 0);
        tv[2]  = mv(mk(100, 20, 15, 15, 0, 16'h1000, 8'h10), 1, 105, 22,
                    0, 8'h03, 0, 16'h0000, 8'h00, 0, 2, 0, 0);
        tv[3]  = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 1, 105, 36,
                    0, 8'h03, 0, 16'h0000, 8'h00, 0, 2, 0, 0);
        tv[4]  = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 1, 116, 22,
                    0, 8'h03, 0, 16'h0000, 8'h00, 0, 2, 0, 0);
        tv[5]  = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 1, 105, 22,
                    0, 8'h00, 1, 16'h1025, 8'h00, 0, 3, 0, 0);
        tv[6]  = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 1, 105, 22,
                    1, 8'hF8, 1, 16'h1025, 8'h08, 1, 4, 0, 0);
        tv[7]  = mv(mk(0, 0, 15, 15, 1, 16'hFFF0, 8'h10), 1, 0, 2,
                    0, 8'h01, 1, 16'h0010, 8'h11, 1, 3, 0, 0);
        tv[8]  = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 1, 105, 22,
                    255, 8'h03, 1, 16'h1025, 8'h00, 0, 17, 0, 1);
        tv[9]  = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 1, 105, 22,
                    2, 8'h03, 1, 16'h1025, 8'h13, 1, 5, 0, 1);
        tv[10] = mv(mk(100, 20, 15, 15, 1, 16'h1000, 8'h10), 1, 99, 22,
                    0, 8'h03, 0, 16'h0000, 8'h00, 0, 2, 0, 1);

        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst mem_stb", mem_stb, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_pixel", out_pixel, 0);
        chk("rst out_opaque", out_opaque, 0);
        chk("rst out_hcursor", out_hcursor, 0);
        chk("rst fetch_err", fetch_err, 0);
        reset = 1'b1;

        mem_ack  = 1'b1;
        mem_data = 8'h07;
        repeat (3) begin
            @(negedge clk);
            chk("idle ack stb", mem_stb, 0);
            chk("idle ack valid", out_valid, 0);
            chk("idle ack in_ready", in_ready, 1);
        end
        mem_ack = 1'b0;

        for (int i = 0; i < 11; i++) run(tv[i], i);

        @(negedge clk);
        in_valid  = 1'b1;
        in_sprite = tv[0].spr;
        in_hit    = 1'b1;
        hcursor   = 10'd105;
        vcursor   = 10'd22;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !mem_stb; c++) @(negedge clk);
        chk("midrst stb seen", mem_stb, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst stb", mem_stb, 0);
        chk("midrst valid", out_valid, 0);
        chk("midrst err", fetch_err, 0);
        chk("midrst addr", mem_addr, 0);
        reset    = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 8'h05;
        repeat (2) @(negedge clk);
        chk("late ack stb", mem_stb, 0);
        chk("late ack valid", out_valid, 0);
        chk("late ack in_ready", in_ready, 1);
        mem_ack = 1'b0;
        r = tv[0];
        r.hold = 0;
        r.err  = 0;
        run(r, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_fetch.md
Name: sprite_pixel_fetch

Overview:
- Downstream consumer of the spritecache CAM lookup result.
- Takes the matched 64-bit sprite descriptor and the current raster position. Checks the vertical hit, computes the texel address, and fetches one palette index from sprite pixel memory over a stb/ack handshake.
- Emits one resolved pixel per accepted request toward the compositor. Also emits a transparency flag, which is set on a miss, on an out-of-range row, for a disabled sprite, when the index is 0, or on a fetch timeout.

Parameters:
- ADDR_W, 16, sprite pixel memory address width; address arithmetic wraps modulo 2^ADDR_W.
- PIX_W, 8, palette index width returned by memory.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting the fetch.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_hit  in  1  spritecache found a matching sprite for this hcursor.
- in_sprite  in  64  descriptor:
  - [9:0] HPOS, [18:10] VPOS, [24:19] WIDTH, [30:25] HEIGHT (WIDTH and HEIGHT are inclusive extents, span = value+1).
  - [31] EN, [47:32] BASE, [55:48] PALOFS, [63:56] reserved.
- hcursor  in  10  raster x of request.
- vcursor  in  10  raster y of request.
- mem_stb  out  1  memory read strobe.
- mem_addr  out  ADDR_W  texel address.
- mem_ack  in  1  read data valid this cycle.
- mem_data  in  PIX_W  palette index.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_pixel  out  PIX_W  palette entry = mem_data + PALOFS (mod 2^PIX_W); 0 when transparent.
- out_opaque  out  1  1 = draw pixel, 0 = transparent.
- out_hcursor  out  10  hcursor of the request, for alignment.
- fetch_err  out  1  sticky; set on timeout; cleared only by reset.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE.
  - mem_stb=0, mem_addr=0, out_valid=0, out_pixel=0, out_opaque=0, out_hcursor=0, fetch_err=0, timeout counter=0.
  - Reset wins over every other event, including mid-fetch with mem_stb high; the outstanding fetch is dropped and a late mem_ack is ignored.
- States: IDLE, CALC, REQ, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_sprite, in_hit, hcursor and vcursor, then go to CALC.
- CALC (1 cycle):
  - dx = hcursor-HPOS and dy = vcursor-VPOS, computed at 10 bits.
  - vhit = (VPOS<=vcursor<=VPOS+HEIGHT), with the sum computed at 11 bits so there is no wrap.
  - If !in_hit, !EN, !vhit, or dx>WIDTH: set out_pixel=0, out_opaque=0, go to OUT with no memory access.
  - Otherwise mem_addr = BASE + dy*(WIDTH+1) + dx, truncated to ADDR_W; go to REQ.
- REQ:
  - mem_stb=1 with mem_addr held stable; the counter increments each cycle.
  - On mem_ack:
    - mem_stb=0 the next cycle.
    - If mem_data==0: out_pixel=0, out_opaque=0.
    - Else: out_pixel=mem_data+PALOFS, out_opaque=1.
    - Go to OUT.
  - If the counter reaches TIMEOUT without ack: mem_stb=0, fetch_err=1, out_pixel=0, out_opaque=0, go to OUT.
  - mem_ack arriving on the same cycle as the timeout takes precedence (data is used, no error).
- OUT:
  - out_valid=1; outputs are held stable while out_ready=0.
  - On out_ready: out_valid=0 and go to IDLE.
  - in_ready is 0 throughout, so a new request is accepted no earlier than the cycle after the handshake.
- Latency, in_valid accept to out_valid:
  - 2 cycles for the no-fetch path.
  - 3+N cycles for a fetch, where N = cycles from mem_stb rise to mem_ack (N>=0 when ack is combinational).
- mem_ack outside REQ is ignored.
- out_hcursor equals the latched hcursor in every path.

Test Plan:
- Reset mid-fetch: assert reset low with mem_stb=1, then release and send an ack -> mem_stb=0 and out_valid=0; the stale ack is ignored; the next request completes normally.
- Fetch hit:
  - Stimulus: HPOS=100, VPOS=20, WIDTH=15, HEIGHT=15, BASE=0x1000, PALOFS=0x10, EN=1, hcursor=105, vcursor=22; mem_ack after 2 cycles with mem_data=0x03.
  - Response: mem_addr=0x1025, out_pixel=0x13, out_opaque=1, out_hcursor=105.
- Skip paths, each with no mem_stb and out_pixel=0, out_opaque=0:
  - in_hit=0.
  - EN=0.
  - vcursor=36 with VPOS=20, HEIGHT=15.
- Transparent texel: mem_data=0x00 -> out_opaque=0, out_pixel=0.
- Timeout: no mem_ack for 15 cycles -> mem_stb drops, fetch_err=1 and stays set, out_opaque=0. A subsequent good fetch succeeds and fetch_err remains 1.
- Backpressure and wrap:
  - out_ready held low for 5 cycles -> outputs stable and in_ready=0 throughout.
  - BASE=0xFFF0 with offset 0x20 -> mem_addr=0x0010.
